// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder: one full-adder cell time-shared over WIDTH cycles
//
// Purpose:
//   Adds a + b + cin one bit per clock, LSB first, using a single 1-bit
//   full-adder cell. The FSM walks IDLE -> RUN (WIDTH cycles) -> DONE (1 cycle)
//   -> IDLE. Starts are only accepted in IDLE; requests made while running
//   are dropped. The result is held on sum/cout until the next accepted start.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request one addition (sampled in IDLE only)
//   a      in   WIDTH  operand A
//   b      in   WIDTH  operand B
//   cin    in   1      carry into bit 0
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse in DONE; sum/cout valid
//   sum    out  WIDTH  (a + b + cin) mod 2^WIDTH
//   cout   out  1      carry out of bit WIDTH-1

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // The counter must be able to reach WIDTH without wrapping.
    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             w_fa_x;
    logic             w_fa_y;
    logic             w_fa_s;
    logic             w_fa_c;
    logic [WIDTH-1:0] w_sum_next;

    // ------------------------------------------------------------------
    // The single full-adder cell
    // ------------------------------------------------------------------
    assign w_fa_x = r_a[0];
    assign w_fa_y = r_b[0];
    assign w_fa_s = w_fa_x ^ w_fa_y ^ r_carry;
    assign w_fa_c = (w_fa_x & w_fa_y) | (w_fa_x & r_carry) | (w_fa_y & r_carry);

    assign w_last = (r_cnt == LAST_BIT);

    // Cell sum enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_next = w_fa_s;
        end else begin : g_sum_wn
            assign w_sum_next = {w_fa_s, r_sum[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // busy/done come straight from flops loaded with the decoded next state,
    // so they always equal (state==RUN)/(state==DONE) without decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next_state == S_RUN);
            r_done <= (w_next_state == S_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Datapath: operand shift registers, carry, result, bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_fa_c;
            r_sum   <= w_sum_next;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // The carry register is left untouched after RUN, so it doubles as cout.
    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1)

module tb_serial_adder_ctrl;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         e0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       s8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       c8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       s1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       c1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    exp_t q8[$];
    exp_t q1[$];
    exp_t last8;
    exp_t last1;
    int   next8 = 0;
    int   next1 = 0;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s8),
        .a     (a8),
        .b     (b8),
        .cin   (c8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s1),
        .a     (a1),
        .b     (b1),
        .cin   (c1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: an idle adder accepts a start; the next one is possible WIDTH+2 edges later.
    task automatic step8(input logic st, input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] t;
        s8 = st; a8 = a; b8 = b; c8 = c;
        @(posedge clk); #1;
        if (st && rst_n && cyc >= next8) begin
            t = {1'b0, a} + {1'b0, b} + {8'd0, c};
            q8.push_back('{t[7:0], t[8], cyc});
            next8 = cyc + 10;
        end
    endtask

    task automatic step1(input logic st, input logic a, input logic b, input logic c);
        int t;
        s1 = st; a1 = a; b1 = b; c1 = c;
        @(posedge clk); #1;
        if (st && rst_n && cyc >= next1) begin
            t = int'(a) + int'(b) + int'(c);
            q1.push_back('{8'(t % 2), (t >= 2), cyc});
            next1 = cyc + 3;
        end
    endtask

    // Monitor, WIDTH=8
    always @(negedge clk) begin
        logic eb, ed;
        exp_t e;
        eb = (q8.size() > 0) && (cyc >= q8[0].e0) && (cyc < q8[0].e0 + 8);
        ed = (q8.size() > 0) && (cyc == q8[0].e0 + 8);
        chk("busy8", 32'(busy8), 32'(eb));
        chk("done8", 32'(done8), 32'(ed));
        if (ed) begin
            e = q8.pop_front();
            if (done8) begin
                chk("sum8", 32'(sum8), 32'(e.sum));
                chk("cout8", 32'(cout8), 32'(e.cout));
                last8 = e;
            end
        end else if (q8.size() == 0) begin
            chk("hold_sum8", 32'(sum8), 32'(last8.sum));
            chk("hold_cout8", 32'(cout8), 32'(last8.cout));
        end
    end

    // Monitor, WIDTH=1
    always @(negedge clk) begin
        logic eb, ed;
        exp_t e;
        eb = (q1.size() > 0) && (cyc == q1[0].e0);
        ed = (q1.size() > 0) && (cyc == q1[0].e0 + 1);
        chk("busy1", 32'(busy1), 32'(eb));
        chk("done1", 32'(done1), 32'(ed));
        if (ed) begin
            e = q1.pop_front();
            if (done1) begin
                chk("sum1", 32'(sum1), 32'(e.sum[0]));
                chk("cout1", 32'(cout1), 32'(e.cout));
                last1 = e;
            end
        end else if (q1.size() == 0) begin
            chk("hold_sum1", 32'(sum1), 32'(last1.sum[0]));
            chk("hold_cout1", 32'(cout1), 32'(last1.cout));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        last8 = '{8'h00, 1'b0, 0};
        last1 = '{8'h00, 1'b0, 0};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_sum8", 32'(sum8), 32'd0);
        chk("rst_cout8", 32'(cout8), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed corner operands
        step8(1'b1, 8'h00, 8'h00, 1'b0);
        repeat (11) step8(1'b0, 8'h00, 8'h00, 1'b0);
        step8(1'b1, 8'hFF, 8'h01, 1'b0);
        repeat (11) step8(1'b0, 8'h00, 8'h00, 1'b0);
        step8(1'b1, 8'hFF, 8'hFF, 1'b1);
        repeat (11) step8(1'b0, 8'h00, 8'h00, 1'b0);

        // Operands change right after acceptance: result must use latched values
        step8(1'b1, 8'h5A, 8'h3C, 1'b1);
        step8(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (10) step8(1'b0, 8'h00, 8'h00, 1'b0);

        // Start held high: accepts every 10 cycles, extra requests dropped
        for (int i = 0; i < 31; i++) step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
        repeat (12) step8(1'b0, 8'h00, 8'h00, 1'b0);

        // Reset in RUN at bit 4: abort, outputs cleared asynchronously
        step8(1'b1, 8'hC3, 8'h7E, 1'b1);
        repeat (4) step8(1'b0, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_busy8", 32'(busy8), 32'd0);
        chk("abort_done8", 32'(done8), 32'd0);
        chk("abort_sum8", 32'(sum8), 32'd0);
        chk("abort_cout8", 32'(cout8), 32'd0);
        q8.delete();
        last8 = '{8'h00, 1'b0, 0};
        next8 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step8(1'b1, 8'h10, 8'h20, 1'b0);
        repeat (11) step8(1'b0, 8'h00, 8'h00, 1'b0);

        // Random traffic with random start spacing
        for (int i = 0; i < 300; i++)
            step8(1'($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom), 1'($urandom));
        repeat (12) step8(1'b0, 8'h00, 8'h00, 1'b0);

        // WIDTH=1: full truth table, then random
        for (int i = 0; i < 8; i++) begin
            step1(1'b1, 1'(i >> 2), 1'(i >> 1), 1'(i));
            repeat (2) step1(1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 40; i++)
            step1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        repeat (4) step1(1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
